jzjpcc_decode_execute_reg: RTL

- Decode-side producer for the decode→execute boundary: the pipeline register that drives the decode modport of jzjpcc_execute_if.
- Captures the decoder's combinational outputs each cycle.
- Holds on downstream stall; squashes on branch flush.
- Detects load-use hazards, inserts one bubble and holds upstream stages. Keeps a saturating bubble counter for performance debug.

---
 rtl/jzjpcc_decode_execute_reg.sv | 130 +++++++++++++
 1 files changed

// File: rtl/jzjpcc_decode_execute_reg.sv
// Decode->execute pipeline register with load-use bubble insertion and a saturating bubble counter.
// Latency 1 cycle; stall holds contents, flush/hazard insert a bubble, upstreamHold freezes fetch/decode.
module jzjpcc_decode_execute_reg #(
    parameter int PC_MAX_B     = 31,
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    dValid,
    input  logic [31:0]             dImmediate,
    input  logic [31:0]             dRs1,
    input  logic [31:0]             dRs2,
    input  logic [PC_MAX_B:2]       dCurrentPC,
    input  logic [4:0]              dRdAddr,
    input  logic [4:0]              dRs1Addr,
    input  logic [4:0]              dRs2Addr,
    input  logic                    dRs1Used,
    input  logic                    dRs2Used,
    input  logic [2:0]              dAluOperation,
    input  logic                    dAluMod,
    input  logic [1:0]              dAluMuxMode,
    input  logic                    dRdWriteEnable,
    input  logic                    dIsLoad,
    input  logic                    stall,
    input  logic                    flush,
    output logic [31:0]             immediate,
    output logic [31:0]             rs1,
    output logic [31:0]             rs2,
    output logic [PC_MAX_B:2]       currentPC,
    output logic [4:0]              rdAddr,
    output logic [2:0]              aluOperation,
    output logic                    aluMod,
    output logic [1:0]              aluMuxMode,
    output logic                    rdWriteEnable,
    output logic                    exValid,
    output logic                    exIsLoad,
    output logic                    upstreamHold,
    output logic [BUBBLE_CNT_W-1:0] bubbleCount
);

    typedef struct packed {
        logic [31:0]       immediate;
        logic [31:0]       rs1;
        logic [31:0]       rs2;
        logic [PC_MAX_B:2] current_pc;
        logic [4:0]        rd_addr;
        logic [2:0]        alu_operation;
        logic              alu_mod;
        logic [1:0]        alu_mux_mode;
        logic              rd_write_enable;
        logic              ex_valid;
        logic              ex_is_load;
    } ex_t;

    ex_t                     ex_q;
    ex_t                     ex_d;
    ex_t                     ex_load;
    logic [BUBBLE_CNT_W-1:0] bubble_count_q;
    logic [BUBBLE_CNT_W-1:0] bubble_count_d;
    logic                    rs1_match;
    logic                    rs2_match;
    logic                    hazard;

    // A load sitting in execute cannot forward until it leaves, so a reader in decode must wait one slot.
    always_comb begin
        rs1_match = dRs1Used && (dRs1Addr == ex_q.rd_addr);
        rs2_match = dRs2Used && (dRs2Addr == ex_q.rd_addr);
        hazard    = dValid && ex_q.ex_valid && ex_q.ex_is_load && ex_q.rd_write_enable
                    && (ex_q.rd_addr != 5'd0) && (rs1_match || rs2_match);
    end

    assign upstreamHold = stall | (hazard & ~flush);

    always_comb begin
        ex_load                 = '0;
        ex_load.immediate       = dImmediate;
        ex_load.rs1             = dRs1;
        ex_load.rs2             = dRs2;
        ex_load.current_pc      = dCurrentPC;
        ex_load.rd_addr         = dRdAddr;
        ex_load.alu_operation   = dAluOperation;
        ex_load.alu_mod         = dAluMod;
        ex_load.alu_mux_mode    = dAluMuxMode;
        ex_load.rd_write_enable = dRdWriteEnable & dValid;
        ex_load.ex_valid        = dValid;
        ex_load.ex_is_load      = dIsLoad & dValid;
    end

    // Priority: flush > stall > hazard > load; a bubble is the all-zero slot.
    always_comb begin
        ex_d           = ex_q;
        bubble_count_d = bubble_count_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            if (hazard) begin
                ex_d = '0;
                if (bubble_count_q != '1) begin
                    bubble_count_d = bubble_count_q + BUBBLE_CNT_W'(1);
                end
            end else begin
                ex_d = ex_load;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q           <= '0;
            bubble_count_q <= '0;
        end else begin
            ex_q           <= ex_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign immediate     = ex_q.immediate;
    assign rs1           = ex_q.rs1;
    assign rs2           = ex_q.rs2;
    assign currentPC     = ex_q.current_pc;
    assign rdAddr        = ex_q.rd_addr;
    assign aluOperation  = ex_q.alu_operation;
    assign aluMod        = ex_q.alu_mod;
    assign aluMuxMode    = ex_q.alu_mux_mode;
    assign rdWriteEnable = ex_q.rd_write_enable;
    assign exValid       = ex_q.ex_valid;
    assign exIsLoad      = ex_q.ex_is_load;
    assign bubbleCount   = bubble_count_q;

endmodule
